traffic_light_monitor: RTL and testbench
========================================

TRAFFIC_LIGHT_MONITOR -- requirements
Module: traffic_light_monitor

Interface
REQ-001 SHALL have parameter DWELL0, default 10, meaning nominal cycles lamp code 4'b1000 is held.
REQ-002 SHALL have parameter DWELL1, default 2, meaning nominal cycles lamp code 4'b0100 is held.
REQ-003 SHALL have parameter DWELL2, default 5, meaning nominal cycles lamp code 4'b0010 is held.
REQ-004 SHALL have parameter TOL, default 1, meaning the allowed ± deviation from each DWELLx; each DWELLx+TOL SHALL be ≤ 254.
REQ-005 SHALL have port clk, input, 1 bit: the single clock, all state on its rising edge.
REQ-006 SHALL have port res_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port en, input, 1 bit: monitor enable.
REQ-008 SHALL have port lamp, input, 4 bits: the light code under observation.
REQ-009 SHALL have port clr_err, input, 1 bit: clears err_sticky.
REQ-010 SHALL have port phase, output, 2 bits: 00 = L0 (1000), 01 = L1 (0100), 10 = L2 (0010), 11 = IDLE/OFF.
REQ-011 SHALL have port dwell, output, 8 bits: consecutive enabled cycles the current code has been held, saturating at 255.
REQ-012 SHALL have port cycles, output, 16 bits: count of completed rounds, wrapping.
REQ-013 SHALL have ports err_code, err_seq and err_dwell, outputs, 1 bit each: single-cycle error pulses.
REQ-014 SHALL have port err_sticky, output, 3 bits: {dwell, seq, code} sticky error flags.

Function
REQ-015 SHALL sample lamp every rising clk edge while en=1; all outputs registered, one-cycle latency from the sample to the response.
REQ-016 SHALL implement states IDLE, OFF, L0, L1 and L2; phase reports 11 for both IDLE and OFF.
REQ-017 SHALL, from IDLE or OFF, move to Lx on a legal code with dwell=1, without a seq or dwell check.
REQ-018 SHALL, on lamp=4'b1111, enter OFF with dwell=0 and no error.
REQ-019 SHALL, in Lx, increment dwell each cycle the same code is held.
REQ-020 SHALL treat L0→L1, L1→L2 and L2→L0 as successor transitions; on one, check the exiting dwell against [DWELLx−TOL, DWELLx+TOL], pulse err_dwell if outside, then enter the new state with dwell=1.
REQ-021 SHALL skip the exit check of REQ-020 if overflow was already flagged in that phase, or if the phase was entered from IDLE or OFF.
REQ-022 SHALL pulse err_dwell exactly once, while holding, on the cycle dwell reaches DWELLx+TOL+1.
REQ-023 SHALL, on a change between legal codes that is not a successor transition, pulse err_seq and resynchronise to the new state with dwell=1.
REQ-024 SHALL, on any code other than 1000, 0100, 0010 or 1111, pulse err_code and go to IDLE with dwell=0.
REQ-025 SHALL increment cycles (mod 2^16) on each L2→L0 successor transition, independent of dwell errors.
REQ-026 SHALL set each err_sticky bit on its pulse and clear all bits on clr_err; a new error SHALL win over a simultaneous clr_err.
REQ-027 SHALL, while en=0, go to IDLE with dwell=0, generate no pulses, and hold cycles and err_sticky.
REQ-028 SHALL keep the dwell counter saturating at 255 and never wrap.

Reset
REQ-029 SHALL, on res_n=0 and regardless of clk, immediately force state IDLE, phase=11, dwell=0, cycles=0, all pulses=0 and err_sticky=000.
REQ-030 SHALL, after release, begin with the first rising edge where res_n=1.

Verification
REQ-031 SHALL cover nominal operation: en=1, lamp 1000×10, 0100×2, 0010×5, 1000 → phase 00→01→10→00, no pulses, cycles=1 one cycle after 1000 returns.
REQ-032 SHALL cover dwell errors: 1000×10 then 0100×4 → err_dwell pulse when dwell=4, none at the next exit; separately 1000×5 after a full round then 0100 → err_dwell pulse, err_sticky=100.
REQ-033 SHALL cover sequence error: 1000×10 then 0010 → err_seq pulse, phase=10, dwell=1.
REQ-034 SHALL cover illegal code: lamp=0110 with clr_err=1 the same cycle → err_code pulse, phase=11, err_sticky=001 retained; next cycle clr_err=1 → 000.
REQ-035 SHALL cover enable: en=0 for 3 cycles with lamp=0110 → no pulses, phase=11, cycles unchanged.
REQ-036 SHALL cover asynchronous reset: res_n=0 mid-L1 between clock edges → outputs reset immediately, cycles=0.

Source files
------------

// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor: watches a 4-bit lamp code, tracks the L0->L1->L2
// rotation, measures how long each lamp is held, counts completed rounds and
// raises single-cycle and sticky error flags for bad codes, bad ordering and
// out-of-tolerance dwell times.
module traffic_light_monitor #(
  parameter int DWELL0 = 10,
  parameter int DWELL1 = 2,
  parameter int DWELL2 = 5,
  parameter int TOL    = 1
) (
  input  logic        clk,
  input  logic        res_n,
  input  logic        en,
  input  logic [3:0]  lamp,
  input  logic        clr_err,
  output logic [1:0]  phase,
  output logic [7:0]  dwell,
  output logic [15:0] cycles,
  output logic        err_code,
  output logic        err_seq,
  output logic        err_dwell,
  output logic [2:0]  err_sticky
);

  typedef enum logic [2:0] {ST_IDLE, ST_OFF, ST_L0, ST_L1, ST_L2} state_t;

  // Tolerance windows; the lower bound clamps at zero for short dwells.
  localparam int MIN0 = (DWELL0 > TOL) ? DWELL0 - TOL : 0;
  localparam int MIN1 = (DWELL1 > TOL) ? DWELL1 - TOL : 0;
  localparam int MIN2 = (DWELL2 > TOL) ? DWELL2 - TOL : 0;
  localparam logic [7:0] LO0 = 8'(MIN0);
  localparam logic [7:0] LO1 = 8'(MIN1);
  localparam logic [7:0] LO2 = 8'(MIN2);
  localparam logic [7:0] HI0 = 8'(DWELL0 + TOL);
  localparam logic [7:0] HI1 = 8'(DWELL1 + TOL);
  localparam logic [7:0] HI2 = 8'(DWELL2 + TOL);

  function automatic logic [7:0] lo_lim(input logic [1:0] p);
    case (p)
      2'd0:    return LO0;
      2'd1:    return LO1;
      default: return LO2;
    endcase
  endfunction

  function automatic logic [7:0] hi_lim(input logic [1:0] p);
    case (p)
      2'd0:    return HI0;
      2'd1:    return HI1;
      default: return HI2;
    endcase
  endfunction

  // Phase code of a state: 0..2 for lamps, 3 for IDLE and OFF.
  function automatic logic [1:0] state_ph(input state_t s);
    case (s)
      ST_L0:   return 2'd0;
      ST_L1:   return 2'd1;
      ST_L2:   return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  function automatic state_t ph_state(input logic [1:0] p);
    case (p)
      2'd0:    return ST_L0;
      2'd1:    return ST_L1;
      2'd2:    return ST_L2;
      default: return ST_IDLE;
    endcase
  endfunction

  function automatic logic [1:0] succ(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  state_t      state_q, state_d;
  logic [1:0]  phase_q, phase_d;
  logic [7:0]  dwell_q, dwell_d;
  logic [15:0] cycles_q, cycles_d;
  logic        ecode_q, ecode_d;
  logic        eseq_q, eseq_d;
  logic        edwell_q, edwell_d;
  logic [2:0]  sticky_q, sticky_d;
  // ovf: overflow already reported in this phase; fresh: phase began from IDLE/OFF
  logic        ovf_q, ovf_d;
  logic        fresh_q, fresh_d;
  logic [1:0]  cur_ph, new_ph;

  // Next-state, counters and error decisions for the sampled lamp code.
  always_comb begin
    state_d  = state_q;
    dwell_d  = dwell_q;
    cycles_d = cycles_q;
    ovf_d    = ovf_q;
    fresh_d  = fresh_q;
    ecode_d  = 1'b0;
    eseq_d   = 1'b0;
    edwell_d = 1'b0;
    sticky_d = sticky_q;
    cur_ph   = state_ph(state_q);
    case (lamp)
      4'b1000: new_ph = 2'd0;
      4'b0100: new_ph = 2'd1;
      4'b0010: new_ph = 2'd2;
      default: new_ph = 2'd3;
    endcase

    if (!en) begin
      state_d = ST_IDLE;
      dwell_d = 8'd0;
    end else begin
      if (lamp == 4'b1111) begin
        state_d = ST_OFF;
        dwell_d = 8'd0;
      end else if (new_ph == 2'd3) begin
        ecode_d = 1'b1;
        state_d = ST_IDLE;
        dwell_d = 8'd0;
      end else if (cur_ph == 2'd3) begin
        state_d = ph_state(new_ph);
        dwell_d = 8'd1;
        fresh_d = 1'b1;
        ovf_d   = 1'b0;
      end else if (new_ph == cur_ph) begin
        dwell_d = (dwell_q == 8'hFF) ? dwell_q : dwell_q + 8'd1;
        if (!ovf_q && (dwell_d == hi_lim(cur_ph) + 8'd1)) begin
          edwell_d = 1'b1;
          ovf_d    = 1'b1;
        end
      end else begin
        if (new_ph == succ(cur_ph)) begin
          if (!ovf_q && !fresh_q &&
              ((dwell_q < lo_lim(cur_ph)) || (dwell_q > hi_lim(cur_ph))))
            edwell_d = 1'b1;
          if (cur_ph == 2'd2)
            cycles_d = cycles_q + 16'd1;
        end else begin
          eseq_d = 1'b1;
        end
        state_d = ph_state(new_ph);
        dwell_d = 8'd1;
        fresh_d = 1'b0;
        ovf_d   = 1'b0;
      end
      if (clr_err)
        sticky_d = 3'b000;
      sticky_d = sticky_d | {edwell_d, eseq_d, ecode_d};
    end
    phase_d = state_ph(state_d);
  end

  // State and registered outputs, forced to idle by the asynchronous reset.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q  <= ST_IDLE;
      phase_q  <= 2'b11;
      dwell_q  <= 8'd0;
      cycles_q <= 16'd0;
      ecode_q  <= 1'b0;
      eseq_q   <= 1'b0;
      edwell_q <= 1'b0;
      sticky_q <= 3'b000;
      ovf_q    <= 1'b0;
      fresh_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      dwell_q  <= dwell_d;
      cycles_q <= cycles_d;
      ecode_q  <= ecode_d;
      eseq_q   <= eseq_d;
      edwell_q <= edwell_d;
      sticky_q <= sticky_d;
      ovf_q    <= ovf_d;
      fresh_q  <= fresh_d;
    end
  end

  assign phase      = phase_q;
  assign dwell      = dwell_q;
  assign cycles     = cycles_q;
  assign err_code   = ecode_q;
  assign err_seq    = eseq_q;
  assign err_dwell  = edwell_q;
  assign err_sticky = sticky_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Bench for traffic_light_monitor: directed scenarios plus randomized lamp
// sequences, every cycle compared against a behavioural model of the rules.
module tb_traffic_light_monitor;

  localparam int TOL = 1;

  logic        clk = 1'b0;
  logic        res_n = 1'b0;
  logic        en = 1'b0;
  logic [3:0]  lamp = 4'b0000;
  logic        clr_err = 1'b0;
  logic [1:0]  phase;
  logic [7:0]  dwell;
  logic [15:0] cycles;
  logic        err_code, err_seq, err_dwell;
  logic [2:0]  err_sticky;

  traffic_light_monitor dut (
    .clk(clk), .res_n(res_n), .en(en), .lamp(lamp), .clr_err(clr_err),
    .phase(phase), .dwell(dwell), .cycles(cycles),
    .err_code(err_code), .err_seq(err_seq), .err_dwell(err_dwell),
    .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Behavioural model: lamp index 0..2, 3 = not showing a lamp (IDLE/OFF).
  int       m_ph, m_dw, m_cyc;
  bit       m_fresh, m_flag;
  bit       m_ec, m_es, m_ed;
  bit [2:0] m_st;

  function automatic int nom(input int k);
    case (k)
      0:       return 10;
      1:       return 2;
      default: return 5;
    endcase
  endfunction

  task automatic model_reset();
    m_ph = 3; m_dw = 0; m_cyc = 0; m_fresh = 0; m_flag = 0;
    m_ec = 0; m_es = 0; m_ed = 0; m_st = 3'b000;
  endtask

  task automatic model_enter(input int k, input bit fresh);
    m_ph = k; m_dw = 1; m_fresh = fresh; m_flag = 0;
  endtask

  task automatic model_step();
    int k;
    m_ec = 0; m_es = 0; m_ed = 0;
    if (!en) begin
      m_ph = 3; m_dw = 0;
      return;
    end
    if (lamp == 4'b1000) k = 0;
    else if (lamp == 4'b0100) k = 1;
    else if (lamp == 4'b0010) k = 2;
    else if (lamp == 4'b1111) k = 3;
    else k = -1;
    if (k == 3) begin
      m_ph = 3; m_dw = 0;
    end else if (k < 0) begin
      m_ec = 1; m_ph = 3; m_dw = 0;
    end else if (m_ph == 3) begin
      model_enter(k, 1);
    end else if (k == m_ph) begin
      m_dw = (m_dw + 1 > 255) ? 255 : m_dw + 1;
      if (!m_flag && m_dw == nom(k) + TOL + 1) begin
        m_ed = 1; m_flag = 1;
      end
    end else if (k == (m_ph + 1) % 3) begin
      if (!m_flag && !m_fresh &&
          (m_dw < nom(m_ph) - TOL || m_dw > nom(m_ph) + TOL))
        m_ed = 1;
      if (m_ph == 2) m_cyc = (m_cyc + 1) % 65536;
      model_enter(k, 0);
    end else begin
      m_es = 1;
      model_enter(k, 0);
    end
    if (clr_err) m_st = 3'b000;
    m_st = m_st | {m_ed, m_es, m_ec};
  endtask

  task automatic check_all();
    chk("phase", phase, m_ph);
    chk("dwell", dwell, m_dw);
    chk("cycles", cycles, m_cyc);
    chk("err_code", err_code, m_ec);
    chk("err_seq", err_seq, m_es);
    chk("err_dwell", err_dwell, m_ed);
    chk("err_sticky", err_sticky, m_st);
  endtask

  // One clock: model consumes the inputs present at the edge, outputs checked after it.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic hold(input logic [3:0] code, input int n);
    lamp = code;
    repeat (n) cycle();
  endtask

  logic [3:0] codes [3];
  int saved_cyc;

  initial begin
    codes[0] = 4'b1000; codes[1] = 4'b0100; codes[2] = 4'b0010;
    model_reset();
    #12;
    chk("rst_phase", phase, 2'b11);
    chk("rst_dwell", dwell, 0);
    chk("rst_cycles", cycles, 0);
    chk("rst_pulses", {err_code, err_seq, err_dwell}, 3'b000);
    chk("rst_sticky", err_sticky, 3'b000);
    res_n = 1'b1;
    en = 1'b1;

    // Nominal round
    hold(4'b1000, 10); hold(4'b0100, 2); hold(4'b0010, 5); hold(4'b1000, 1);
    chk("nom_cycles", cycles, 1);
    chk("nom_phase", phase, 2'b00);
    chk("nom_sticky", err_sticky, 3'b000);

    // Over-long L1: pulse at dwell 4, no second pulse on exit
    hold(4'b1000, 9); hold(4'b0100, 4);
    chk("ovf_pulse", err_dwell, 1);
    chk("ovf_dwell", dwell, 4);
    hold(4'b0010, 1);
    chk("ovf_exit_quiet", err_dwell, 0);
    hold(4'b0010, 4);
    clr_err = 1'b1; hold(4'b1000, 1); clr_err = 1'b0;
    hold(4'b1000, 4); hold(4'b0100, 1);
    chk("short_pulse", err_dwell, 1);
    chk("short_sticky", err_sticky, 3'b100);

    // Sequence error
    hold(4'b1111, 1); hold(4'b1000, 10); hold(4'b0010, 1);
    chk("seq_pulse", err_seq, 1);
    chk("seq_phase", phase, 2'b10);
    chk("seq_dwell", dwell, 1);

    // Illegal code with simultaneous clear
    clr_err = 1'b1; hold(4'b0110, 1);
    chk("code_pulse", err_code, 1);
    chk("code_phase", phase, 2'b11);
    chk("code_sticky", err_sticky, 3'b001);
    hold(4'b1111, 1); clr_err = 1'b0;
    chk("clr_sticky", err_sticky, 3'b000);

    // Enable low
    saved_cyc = int'(cycles);
    en = 1'b0; hold(4'b0110, 3);
    chk("en_pulses", {err_code, err_seq, err_dwell}, 3'b000);
    chk("en_phase", phase, 2'b11);
    chk("en_cycles", cycles, saved_cyc);
    en = 1'b1;

    // Dwell saturation
    hold(4'b1000, 260);
    chk("sat_dwell", dwell, 255);

    // Async reset mid-L1, between edges
    hold(4'b0100, 1);
    #3; res_n = 1'b0; #1;
    model_reset();
    check_all();
    chk("arst_cycles", cycles, 0);
    #2; res_n = 1'b1;

    // Randomized traffic
    begin
      int nidx = 0;
      for (int r = 0; r < 400; r++) begin
        int sel = int'($urandom_range(0, 99));
        int len;
        logic [3:0] code;
        if (sel < 70) begin
          nidx = (nidx + 1) % 3;
          code = codes[nidx];
          len = nom(nidx) + int'($urandom_range(0, 4)) - 2;
          if (len < 1) len = 1;
        end else if (sel < 80) begin
          nidx = int'($urandom_range(0, 2));
          code = codes[nidx];
          len = int'($urandom_range(1, 12));
        end else if (sel < 87) begin
          code = 4'b1111;
          len = int'($urandom_range(1, 3));
        end else if (sel < 94) begin
          code = 4'($urandom_range(0, 15));
          len = int'($urandom_range(1, 3));
        end else begin
          en = 1'b0;
          code = 4'($urandom_range(0, 15));
          len = int'($urandom_range(1, 3));
        end
        for (int c = 0; c < len; c++) begin
          clr_err = ($urandom_range(0, 19) == 0);
          lamp = code;
          cycle();
        end
        en = 1'b1;
        clr_err = 1'b0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
